// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter: collects completed results from NUM_SRC functional-unit
// sources into private one-entry holding registers and schedules up to
// WB_WIDTH of them per cycle onto the ROB writeback ports using a rotating
// priority scan. Writeback outputs depend only on held state (and flush_i),
// never on same-cycle source inputs.
module rob_wb_arbiter #(
  parameter int NUM_SRC   = 6,
  parameter int WB_WIDTH  = 4,
  parameter int ROB_IDX_W = 6,
  parameter int XLEN      = 32,
  parameter int PLEN      = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [NUM_SRC-1:0]                   src_valid_i,
  output logic [NUM_SRC-1:0]                   src_ready_o,
  input  logic [NUM_SRC*ROB_IDX_W-1:0]         src_rob_idx_i,
  input  logic [NUM_SRC*XLEN-1:0]              src_data_i,
  input  logic [NUM_SRC-1:0]                   src_exception_i,
  input  logic [NUM_SRC*5-1:0]                 src_ecause_i,
  input  logic [NUM_SRC-1:0]                   src_is_mispred_i,
  input  logic [NUM_SRC*PLEN-1:0]              src_redirect_pc_i,
  output logic [WB_WIDTH-1:0]                  wb_valid_o,
  output logic [WB_WIDTH*ROB_IDX_W-1:0]        wb_rob_index_o,
  output logic [WB_WIDTH*XLEN-1:0]             wb_data_o,
  output logic [WB_WIDTH-1:0]                  wb_exception_o,
  output logic [WB_WIDTH*5-1:0]                wb_ecause_o,
  output logic [WB_WIDTH-1:0]                  wb_is_mispred_o,
  output logic [WB_WIDTH*PLEN-1:0]             wb_redirect_pc_o,
  output logic [WB_WIDTH*$clog2(NUM_SRC)-1:0]  wb_src_id_o,
  output logic [31:0]                          conflict_cnt_o
);

  localparam int SID_W  = $clog2(NUM_SRC);
  localparam int SCAN_W = SID_W + 1;
  localparam int CNT_W  = $clog2(WB_WIDTH + 1);
  localparam int POP_W  = $clog2(NUM_SRC + 1);

  // Number of occupied holding registers.
  function automatic logic [POP_W-1:0] popcount(input logic [NUM_SRC-1:0] vec);
    logic [POP_W-1:0] acc;
    acc = {POP_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      acc = acc + POP_W'(vec[i]);
    end
    return acc;
  endfunction

  // Holding registers, one per source.
  logic [NUM_SRC-1:0]   full_r;
  logic [ROB_IDX_W-1:0] idx_r     [NUM_SRC];
  logic [XLEN-1:0]      data_r    [NUM_SRC];
  logic [NUM_SRC-1:0]   exc_r;
  logic [4:0]           ecause_r  [NUM_SRC];
  logic [NUM_SRC-1:0]   mispred_r;
  logic [PLEN-1:0]      rpc_r     [NUM_SRC];

  // Scheduler state.
  logic [SID_W-1:0]     rr_ptr_r;
  logic [31:0]          conflict_cnt_r;

  // Arbitration results.
  logic [NUM_SRC-1:0]   grant_s;
  logic [CNT_W-1:0]     grant_cnt_s;
  logic [SID_W-1:0]     last_s;
  logic [SCAN_W-1:0]    scan_s;
  logic [WB_WIDTH-1:0]  port_vld_s;
  logic [SID_W-1:0]     port_sel_s [WB_WIDTH];
  logic [SID_W-1:0]     rr_next_s;
  logic                 conflict_s;

  // Rotating scan from rr_ptr over held results; the k-th hit drives port k.
  always_comb begin
    grant_s     = {NUM_SRC{1'b0}};
    grant_cnt_s = {CNT_W{1'b0}};
    last_s      = rr_ptr_r;
    scan_s      = {SCAN_W{1'b0}};
    port_vld_s  = {WB_WIDTH{1'b0}};
    for (int p = 0; p < WB_WIDTH; p++) begin
      port_sel_s[p] = {SID_W{1'b0}};
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      scan_s = {1'b0, rr_ptr_r} + SCAN_W'(i);
      if (scan_s >= SCAN_W'(NUM_SRC)) begin
        scan_s = scan_s - SCAN_W'(NUM_SRC);
      end else begin
        scan_s = scan_s;
      end
      if (!flush_i && full_r[scan_s[SID_W-1:0]] && (grant_cnt_s < CNT_W'(WB_WIDTH))) begin
        grant_s[scan_s[SID_W-1:0]] = 1'b1;
        for (int p = 0; p < WB_WIDTH; p++) begin
          if (CNT_W'(p) == grant_cnt_s) begin
            port_vld_s[p] = 1'b1;
            port_sel_s[p] = scan_s[SID_W-1:0];
          end else begin
            port_vld_s[p] = port_vld_s[p];
          end
        end
        last_s      = scan_s[SID_W-1:0];
        grant_cnt_s = grant_cnt_s + CNT_W'(1);
      end else begin
        grant_cnt_s = grant_cnt_s;
      end
    end
  end

  // Next scan start: one past the last granted source, wrapping to zero.
  always_comb begin
    if (grant_cnt_s == {CNT_W{1'b0}}) begin
      rr_next_s = rr_ptr_r;
    end else if (last_s == SID_W'(NUM_SRC - 1)) begin
      rr_next_s = {SID_W{1'b0}};
    end else begin
      rr_next_s = last_s + SID_W'(1);
    end
  end

  // Overload detection: more results held than there are writeback ports.
  always_comb begin
    if (flush_i) begin
      conflict_s = 1'b0;
    end else begin
      conflict_s = (popcount(full_r) > POP_W'(WB_WIDTH));
    end
  end

  // Ready: an empty slot, or one being released this cycle, may be refilled.
  always_comb begin
    if (flush_i) begin
      src_ready_o = {NUM_SRC{1'b0}};
    end else begin
      src_ready_o = ~full_r | grant_s;
    end
  end

  // Writeback port bundle: selected payloads, unused ports fully zeroed.
  always_comb begin
    wb_valid_o       = {WB_WIDTH{1'b0}};
    wb_rob_index_o   = {(WB_WIDTH*ROB_IDX_W){1'b0}};
    wb_data_o        = {(WB_WIDTH*XLEN){1'b0}};
    wb_exception_o   = {WB_WIDTH{1'b0}};
    wb_ecause_o      = {(WB_WIDTH*5){1'b0}};
    wb_is_mispred_o  = {WB_WIDTH{1'b0}};
    wb_redirect_pc_o = {(WB_WIDTH*PLEN){1'b0}};
    wb_src_id_o      = {(WB_WIDTH*SID_W){1'b0}};
    for (int p = 0; p < WB_WIDTH; p++) begin
      if (port_vld_s[p]) begin
        wb_valid_o[p]                           = 1'b1;
        wb_rob_index_o[p*ROB_IDX_W +: ROB_IDX_W] = idx_r[port_sel_s[p]];
        wb_data_o[p*XLEN +: XLEN]               = data_r[port_sel_s[p]];
        wb_exception_o[p]                       = exc_r[port_sel_s[p]];
        wb_ecause_o[p*5 +: 5]                   = ecause_r[port_sel_s[p]];
        wb_is_mispred_o[p]                      = mispred_r[port_sel_s[p]];
        wb_redirect_pc_o[p*PLEN +: PLEN]        = rpc_r[port_sel_s[p]];
        wb_src_id_o[p*SID_W +: SID_W]           = port_sel_s[p];
      end else begin
        wb_valid_o[p] = 1'b0;
      end
    end
  end

  // Holding registers: flush drops all, a new accept wins over a release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_r    <= {NUM_SRC{1'b0}};
      exc_r     <= {NUM_SRC{1'b0}};
      mispred_r <= {NUM_SRC{1'b0}};
      for (int s = 0; s < NUM_SRC; s++) begin
        idx_r[s]    <= {ROB_IDX_W{1'b0}};
        data_r[s]   <= {XLEN{1'b0}};
        ecause_r[s] <= 5'd0;
        rpc_r[s]    <= {PLEN{1'b0}};
      end
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (flush_i) begin
          full_r[s] <= 1'b0;
        end else if (src_valid_i[s] && src_ready_o[s]) begin
          full_r[s]    <= 1'b1;
          idx_r[s]     <= src_rob_idx_i[s*ROB_IDX_W +: ROB_IDX_W];
          data_r[s]    <= src_data_i[s*XLEN +: XLEN];
          exc_r[s]     <= src_exception_i[s];
          ecause_r[s]  <= src_ecause_i[s*5 +: 5];
          mispred_r[s] <= src_is_mispred_i[s];
          rpc_r[s]     <= src_redirect_pc_i[s*PLEN +: PLEN];
        end else if (grant_s[s]) begin
          full_r[s] <= 1'b0;
        end else begin
          full_r[s] <= full_r[s];
        end
      end
    end
  end

  // Round-robin pointer: restarts at zero on flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_r <= {SID_W{1'b0}};
    end else if (flush_i) begin
      rr_ptr_r <= {SID_W{1'b0}};
    end else begin
      rr_ptr_r <= rr_next_s;
    end
  end

  // Saturating overload counter; survives flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_r <= 32'd0;
    end else if (conflict_s && (conflict_cnt_r != 32'hFFFF_FFFF)) begin
      conflict_cnt_r <= conflict_cnt_r + 32'd1;
    end else begin
      conflict_cnt_r <= conflict_cnt_r;
    end
  end

  assign conflict_cnt_o = conflict_cnt_r;

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Directed and randomized bench for rob_wb_arbiter, checked against a
// queue-based reference model of the writeback scheduler.
module tb_rob_wb_arbiter;

  localparam int NS = 6;
  localparam int WW = 4;
  localparam int RW = 6;
  localparam int XL = 32;
  localparam int PL = 32;
  localparam int SW = 3;

  typedef struct packed {
    logic [RW-1:0] idx;
    logic [XL-1:0] data;
    logic          exc;
    logic [4:0]    ec;
    logic          mis;
    logic [PL-1:0] pc;
  } pay_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_flush;
  logic [NS-1:0] in_valid;
  pay_t in_pay [NS];

  logic [NS-1:0]    src_ready;
  logic [NS*RW-1:0] src_idx;
  logic [NS*XL-1:0] src_data;
  logic [NS-1:0]    src_exc;
  logic [NS*5-1:0]  src_ec;
  logic [NS-1:0]    src_mis;
  logic [NS*PL-1:0] src_pc;

  logic [WW-1:0]    wb_valid;
  logic [WW*RW-1:0] wb_idx;
  logic [WW*XL-1:0] wb_data;
  logic [WW-1:0]    wb_exc;
  logic [WW*5-1:0]  wb_ec;
  logic [WW-1:0]    wb_mis;
  logic [WW*PL-1:0] wb_pc;
  logic [WW*SW-1:0] wb_sid;
  logic [31:0]      conflict_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [NS-1:0] m_full;
  pay_t          m_pay [NS];
  int            m_rr;
  logic [31:0]   m_cnt;

  rob_wb_arbiter #(.NUM_SRC(NS), .WB_WIDTH(WW), .ROB_IDX_W(RW), .XLEN(XL), .PLEN(PL)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (in_flush),
    .src_valid_i      (in_valid),
    .src_ready_o      (src_ready),
    .src_rob_idx_i    (src_idx),
    .src_data_i       (src_data),
    .src_exception_i  (src_exc),
    .src_ecause_i     (src_ec),
    .src_is_mispred_i (src_mis),
    .src_redirect_pc_i(src_pc),
    .wb_valid_o       (wb_valid),
    .wb_rob_index_o   (wb_idx),
    .wb_data_o        (wb_data),
    .wb_exception_o   (wb_exc),
    .wb_ecause_o      (wb_ec),
    .wb_is_mispred_o  (wb_mis),
    .wb_redirect_pc_o (wb_pc),
    .wb_src_id_o      (wb_sid),
    .conflict_cnt_o   (conflict_cnt)
  );

  initial forever #5 clk = ~clk;

  // Flatten per-source payload structs onto the DUT input buses.
  always_comb begin
    src_idx = '0; src_data = '0; src_exc = '0; src_ec = '0; src_mis = '0; src_pc = '0;
    for (int s = 0; s < NS; s++) begin
      src_idx[s*RW +: RW]  = in_pay[s].idx;
      src_data[s*XL +: XL] = in_pay[s].data;
      src_exc[s]           = in_pay[s].exc;
      src_ec[s*5 +: 5]     = in_pay[s].ec;
      src_mis[s]           = in_pay[s].mis;
      src_pc[s*PL +: PL]   = in_pay[s].pc;
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pay_t rnd_pay();
    pay_t p;
    p.idx  = RW'($urandom);
    p.data = $urandom;
    p.exc  = 1'($urandom);
    p.ec   = 5'($urandom);
    p.mis  = 1'($urandom);
    p.pc   = $urandom;
    return p;
  endfunction

  task automatic model_reset();
    m_full = '0;
    m_rr   = 0;
    m_cnt  = 32'd0;
    for (int s = 0; s < NS; s++) m_pay[s] = '0;
  endtask

  task automatic randomize_all_pay();
    for (int s = 0; s < NS; s++) in_pay[s] = rnd_pay();
  endtask

  // One clock cycle: compare DUT against the model, then advance the model.
  task automatic step();
    int held[$];
    int g[$];
    logic [NS-1:0]    gm, e_ready;
    logic [WW-1:0]    e_valid, e_exc, e_mis;
    logic [WW*RW-1:0] e_idx;
    logic [WW*XL-1:0] e_data;
    logic [WW*5-1:0]  e_ec;
    logic [WW*PL-1:0] e_pc;
    logic [WW*SW-1:0] e_sid;
    #1;
    for (int d = 0; d < NS; d++) begin
      if (m_full[(m_rr + d) % NS]) held.push_back((m_rr + d) % NS);
    end
    if (!in_flush) begin
      for (int k = 0; k < held.size() && k < WW; k++) g.push_back(held[k]);
    end
    gm = '0; e_valid = '0; e_exc = '0; e_mis = '0; e_idx = '0;
    e_data = '0; e_ec = '0; e_pc = '0; e_sid = '0;
    foreach (g[k]) begin
      gm[g[k]]           = 1'b1;
      e_valid[k]         = 1'b1;
      e_idx[k*RW +: RW]  = m_pay[g[k]].idx;
      e_data[k*XL +: XL] = m_pay[g[k]].data;
      e_exc[k]           = m_pay[g[k]].exc;
      e_ec[k*5 +: 5]     = m_pay[g[k]].ec;
      e_mis[k]           = m_pay[g[k]].mis;
      e_pc[k*PL +: PL]   = m_pay[g[k]].pc;
      e_sid[k*SW +: SW]  = SW'(g[k]);
    end
    for (int s = 0; s < NS; s++) e_ready[s] = !in_flush && (!m_full[s] || gm[s]);
    check("wb_valid", 256'(wb_valid), 256'(e_valid));
    check("src_ready", 256'(src_ready), 256'(e_ready));
    check("wb_rob_index", 256'(wb_idx), 256'(e_idx));
    check("wb_data", 256'(wb_data), 256'(e_data));
    check("wb_exception", 256'(wb_exc), 256'(e_exc));
    check("wb_ecause", 256'(wb_ec), 256'(e_ec));
    check("wb_is_mispred", 256'(wb_mis), 256'(e_mis));
    check("wb_redirect_pc", 256'(wb_pc), 256'(e_pc));
    check("wb_src_id", 256'(wb_sid), 256'(e_sid));
    check("conflict_cnt", 256'(conflict_cnt), 256'(m_cnt));
    if (in_flush) begin
      m_full = '0;
      m_rr   = 0;
    end else begin
      if (held.size() > WW && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (g.size() > 0) m_rr = (g[g.size()-1] + 1) % NS;
      for (int s = 0; s < NS; s++) begin
        if (in_valid[s] && e_ready[s]) begin
          m_full[s] = 1'b1;
          m_pay[s]  = in_pay[s];
        end else if (gm[s]) begin
          m_full[s] = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    pay_t pa, pb;
    rst_n    = 1'b0;
    in_flush = 1'b0;
    in_valid = '0;
    for (int s = 0; s < NS; s++) in_pay[s] = '0;
    model_reset();
    #2;
    check("rst_valid", 256'(wb_valid), 256'(4'b0000));
    check("rst_ready", 256'(src_ready), 256'(6'b111111));
    check("rst_cnt", 256'(conflict_cnt), 256'(32'd0));
    #10;
    rst_n = 1'b1;
    @(negedge clk);

    // Overload with all sources valid every cycle.
    in_valid = 6'b111111;
    randomize_all_pay();
    step();
    check("ovl1_sid", 256'(wb_sid), 256'(12'h688));
    check("ovl1_valid", 256'(wb_valid), 256'(4'b1111));
    check("ovl1_ready", 256'(src_ready), 256'(6'b001111));
    check("ovl1_cnt", 256'(conflict_cnt), 256'(32'd0));
    randomize_all_pay();
    step();
    check("ovl2_sid", 256'(wb_sid), 256'(12'h22C));
    check("ovl2_ready", 256'(src_ready), 256'(6'b110011));
    check("ovl2_cnt", 256'(conflict_cnt), 256'(32'd1));
    randomize_all_pay();
    step();
    check("ovl3_sid", 256'(wb_sid), 256'(12'hB1A));
    check("ovl3_cnt", 256'(conflict_cnt), 256'(32'd2));

    // Asynchronous reset mid-cycle with every slot full.
    in_valid = '0;
    rst_n    = 1'b0;
    #1;
    check("arst_valid", 256'(wb_valid), 256'(4'b0000));
    check("arst_ready", 256'(src_ready), 256'(6'b111111));
    check("arst_cnt", 256'(conflict_cnt), 256'(32'd0));
    check("arst_data", 256'(wb_data), 256'(0));
    check("arst_sid", 256'(wb_sid), 256'(0));
    model_reset();
    #1;
    rst_n = 1'b1;

    // Single-source latency.
    pa      = rnd_pay();
    pa.idx  = 6'd5;
    pa.data = 32'h0000_DEAD;
    in_pay[2] = pa;
    in_valid  = 6'b000100;
    step();
    check("lat_valid", 256'(wb_valid), 256'(4'b0001));
    check("lat_idx", 256'(wb_idx[RW-1:0]), 256'(6'd5));
    check("lat_sid", 256'(wb_sid[SW-1:0]), 256'(3'd2));
    check("lat_data", 256'(wb_data[XL-1:0]), 256'(32'h0000_DEAD));
    in_valid = '0;
    step();
    check("lat_drain", 256'(wb_valid), 256'(4'b0000));

    // Back-to-back refill of source 1.
    pa = rnd_pay(); pa.data = 32'hA5A5_0001;
    pb = rnd_pay(); pb.data = 32'hB5B5_0002;
    in_pay[1] = pa;
    in_valid  = 6'b000010;
    step();
    in_pay[1] = pb;
    #1;
    check("b2b_ready", 256'(src_ready[1]), 256'(1'b1));
    check("b2b_dataA", 256'(wb_data[XL-1:0]), 256'(32'hA5A5_0001));
    step();
    check("b2b_valid", 256'(wb_valid), 256'(4'b0001));
    check("b2b_dataB", 256'(wb_data[XL-1:0]), 256'(32'hB5B5_0002));
    check("b2b_sid", 256'(wb_sid[SW-1:0]), 256'(3'd1));
    in_valid = '0;
    step();

    // Flush with every slot full.
    in_valid = 6'b111111;
    randomize_all_pay();
    step();
    in_flush = 1'b1;
    #1;
    check("fl_valid", 256'(wb_valid), 256'(4'b0000));
    check("fl_ready", 256'(src_ready), 256'(6'b000000));
    step();
    in_flush = 1'b0;
    in_valid = '0;
    #1;
    check("fl_after_valid", 256'(wb_valid), 256'(4'b0000));
    check("fl_after_ready", 256'(src_ready), 256'(6'b111111));
    in_valid = 6'b111111;
    randomize_all_pay();
    step();
    check("fl_rr0_sid", 256'(wb_sid), 256'(12'h688));
    in_valid = '0;
    for (int i = 0; i < 4; i++) step();

    // Wrap-around: rr_ptr reaches 5 via source 4, then sources 5 and 0.
    randomize_all_pay();
    in_valid = 6'b010000;
    step();
    in_valid = 6'b100001;
    step();
    check("wrap_valid", 256'(wb_valid), 256'(4'b0011));
    check("wrap_sid", 256'(wb_sid), 256'(12'h005));
    in_valid = '0;
    step();
    in_valid = 6'b111111;
    randomize_all_pay();
    step();
    check("wrap_rr1_sid", 256'(wb_sid), 256'(12'h8D1));
    in_valid = '0;
    for (int i = 0; i < 3; i++) step();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      int dens;
      dens = (i / 100) % 4;
      for (int s = 0; s < NS; s++) begin
        in_valid[s] = ($urandom_range(3, 0) < 32'(dens + 1));
        in_pay[s]   = rnd_pay();
      end
      in_flush = ($urandom_range(19, 0) == 0);
      step();
    end
    in_flush = 1'b0;
    in_valid = '0;
    for (int i = 0; i < 4; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
